// File: rtl/ir_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ir_fetch
// Purpose  : Instruction fetch and instruction register. Holds opcode,
//            modebits and operand steady for the T-states of an instruction.
//            Optional one-entry prefetch buffer enabled by IR_FETCH_PREFETCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ir_fetch #(
  parameter int unsigned         ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  input  logic              instr_done,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              stall,
  output logic [5:0]        opcode,
  output logic [1:0]        modebits,
  output logic [7:0]        operand,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              mem_req_q, mem_req_d;
  logic              req_en;
  logic              xfer;
`ifdef IR_FETCH_PREFETCH_EN
  logic [15:0]       pf_buf_q, pf_buf_d;
  logic              pf_valid_q, pf_valid_d;
`endif

  assign xfer = mem_req_q && mem_rvalid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    req_en     = 1'b0;
`ifdef IR_FETCH_PREFETCH_EN
    pf_buf_d   = pf_buf_q;
    pf_valid_d = pf_valid_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        req_en = 1'b1;
        if (xfer) begin
          ir_d       = mem_rdata;
          pc_d       = pc_q + 1'b1;
          ir_valid_d = 1'b1;
          state_d    = S_EXEC;
`ifndef IR_FETCH_PREFETCH_EN
          req_en     = 1'b0;
`endif
        end
      end
      S_EXEC: begin
`ifdef IR_FETCH_PREFETCH_EN
        req_en = 1'b1;
        if (instr_done) begin
          if (branch_en) begin
            // A same-cycle transfer belongs to the abandoned path: drop it.
            pf_valid_d = 1'b0;
            pc_d       = branch_addr;
            ir_valid_d = 1'b0;
            state_d    = S_FETCH;
          end else if (pf_valid_q) begin
            ir_d       = pf_buf_q;
            pf_valid_d = 1'b0;
          end else if (xfer) begin
            ir_d = mem_rdata;
            pc_d = pc_q + 1'b1;
          end else begin
            ir_valid_d = 1'b0;
            state_d    = S_FETCH;
          end
        end else if (xfer) begin
          pf_buf_d   = mem_rdata;
          pf_valid_d = 1'b1;
          pc_d       = pc_q + 1'b1;
        end
`else
        if (instr_done) begin
          ir_valid_d = 1'b0;
          state_d    = S_FETCH;
          req_en     = 1'b1;
          if (branch_en) begin
            pc_d = branch_addr;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Request is registered, so stall withdraws it one edge later.
`ifdef IR_FETCH_PREFETCH_EN
    mem_req_d = req_en && !stall && !pf_valid_d;
`else
    mem_req_d = req_en && !stall;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      mem_req_q  <= 1'b0;
`ifdef IR_FETCH_PREFETCH_EN
      pf_buf_q   <= '0;
      pf_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      mem_req_q  <= mem_req_d;
`ifdef IR_FETCH_PREFETCH_EN
      pf_buf_q   <= pf_buf_d;
      pf_valid_q <= pf_valid_d;
`endif
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign opcode   = ir_q[15:10];
  assign modebits = ir_q[9:8];
  assign operand  = ir_q[7:0];
  assign ir_valid = ir_valid_q;

endmodule
`default_nettype wire

// File: doc/ir_fetch.md
# ir_fetch

Instruction fetch and instruction-register stage that feeds the source-phase timing counter and control decoder. It drives a simple request/valid memory handshake from a program counter and latches the returned word into the instruction register. It presents `opcode`, `modebits` and `operand` steady for the whole T-state sequence of an instruction. It advances only when the sequencer signals the end of the instruction, with an optional one-entry prefetch buffer.

## Interface
Parameters:
- `ADDR_W`, default 8: program counter and memory address width.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_req` out 1: fetch request; `mem_addr` is valid while it is high.
- `mem_addr` out ADDR_W: fetch address.
- `mem_rdata` in 16: instruction word.
- `mem_rvalid` in 1: data valid; a transfer completes in any cycle with `mem_req && mem_rvalid`.
- `instr_done` in 1: one-cycle pulse from the sequencer on the last T-state of the current instruction.
- `branch_en` in 1: redirect request, sampled only together with `instr_done`.
- `branch_addr` in ADDR_W: redirect target.
- `stall` in 1: blocks issue of new requests.
- `opcode` out 6: IR[15:10].
- `modebits` out 2: IR[9:8].
- `operand` out 8: IR[7:0].
- `ir_valid` out 1: the IR holds an instruction under execution.
- `pc` out ADDR_W: address of the next word to fetch.

## Operation
- States: `S_IDLE` (reset), `S_FETCH`, `S_EXEC`.
- `S_IDLE` always moves to `S_FETCH` on the next edge.
- `S_FETCH`:
  - `mem_req = !stall`, `mem_addr = pc`.
  - On transfer: IR <= `mem_rdata`, `pc <= pc+1`, `ir_valid <= 1`, go to `S_EXEC`.
  - `instr_done` is ignored in this state.
- `S_EXEC` on `instr_done`:
  - With `branch_en`: `pc <= branch_addr`, `ir_valid <= 0`, go to `S_FETCH`.
  - Otherwise: `ir_valid <= 0`, go to `S_FETCH`.
  - The IR holds its old value until the next transfer.
- `mem_req` is low in `S_IDLE` and in `S_EXEC` (except when prefetch is enabled, see Configuration).
- PC arithmetic is modulo 2^ADDR_W. `pc` wraps from all-ones to 0 with no flag.
- `stall` never delays the acceptance of `instr_done`. It only suppresses or withdraws `mem_req`.
  - A transfer cannot complete in a cycle where `mem_req` is low.
  - Memory must ignore `mem_rvalid` when `mem_req` is low.

## Timing
- Reset values:
  - state `S_IDLE`, `pc = RESET_PC`, IR = 0 (so `opcode`, `modebits`, `operand` read 0).
  - `ir_valid = 0`, `mem_req = 0`, `mem_addr = RESET_PC`.
  - Prefetch buffer empty.
- After `rst_n` deasserts: `mem_req` rises at the second edge. With zero-wait memory (`mem_rvalid` already high), `ir_valid` rises at the third edge.
- Fetch latency is 1 cycle from the `mem_req` rise with zero-wait memory, plus the number of wait cycles otherwise.
- `mem_addr` stays stable while `mem_req` is high and no transfer has completed.
- Outputs are registered. The IR changes only on the edge that completes a transfer (or a prefetch-buffer load).
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight transfer is abandoned.
- Instruction issue rate without prefetch: one idle T-gap (`ir_valid = 0`) of at least 1 cycle between instructions.

## Configuration
- Macro `IR_FETCH_PREFETCH_EN`.
- When defined, the one-entry buffer `pf_buf`/`pf_valid` is active:
  - In `S_EXEC`, `mem_req = !stall && !pf_valid`, `mem_addr = pc`.
  - On transfer: `pf_buf <= rdata`, `pf_valid <= 1`, `pc <= pc+1`.
- On `instr_done` without branch, when prefetch is enabled:
  - If `pf_valid`: IR <= `pf_buf`, `pf_valid <= 0`. Stay in `S_EXEC` with `ir_valid` held at 1 (zero-gap issue).
  - Else if a transfer completes in the same cycle: IR <= `mem_rdata`, `pc <= pc+1`, stay in `S_EXEC`.
  - Else: go to `S_FETCH`.
- On `instr_done` with branch, when prefetch is enabled: `pf_valid <= 0`. Any same-cycle transfer is discarded (no pc increment). `pc <= branch_addr`, go to `S_FETCH`.
- Not defined: no buffer logic. `mem_req` is never high in `S_EXEC`.

## Test plan
- Reset release, zero-wait memory returning 0x8A05 at address 0:
  - `opcode = 6'b100010`, `modebits = 2'b10`, `operand = 0x05`, `ir_valid = 1` at the third edge.
  - `pc = 1`.
- 2-cycle memory wait: `mem_addr` is held at 1 for all cycles with `mem_req` high, and the IR updates only on the edge where `mem_rvalid` is high.
- `instr_done` plus `branch_en` with `branch_addr = 0x40` during execution:
  - Next fetch uses `mem_addr = 0x40`.
  - With prefetch, the buffered word is dropped and `pc` becomes 0x41 after the fetch.
- PC wrap:
  - `RESET_PC = 0xFF` with `ADDR_W = 8`: after the first fetch, `pc = 0x00`, and the next request uses address 0x00.
- `stall` held high for 5 cycles in `S_FETCH`:
  - `mem_req = 0` throughout, no IR change.
  - The request resumes one cycle after `stall` drops.
- Prefetch enabled, zero-wait memory, `instr_done` every 3 cycles:
  - `ir_valid` stays 1 continuously.
  - The IR sequences through addresses 0, 1, 2, 3 in order.
  - Reset asserted mid-sequence clears `pf_valid` and restarts at `RESET_PC`.
